// File: rtl/lifo_stack_pkg.sv
`default_nettype none
// ============================================================================
// Package  : stack_pkg
// Brief    : Shared overflow-policy constants and operation decode for lifo_stack.
// Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int OVF_REJECT = 0;
    localparam int OVF_WRAP   = 1;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_t;

    // A push+pop on an empty stack degrades to a plain push; the rejected pop
    // is flagged separately as an underflow.
    function automatic stack_op_t decode_op(input logic en, input logic push,
                                            input logic pop, input logic empty);
        stack_op_t op;
        op = OP_NOP;
        if (en) begin
            if (push && pop && !empty) begin
                op = OP_REPLACE;
            end else if (push) begin
                op = OP_PUSH;
            end else if (pop && !empty) begin
                op = OP_POP;
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_stack_if.sv
`default_nettype none
// ============================================================================
// Interface : lifo_stack_if
// Brief     : Request/response bundle between a stack user and lifo_stack.
// Revision  : 1.0 - initial release
// ============================================================================
interface lifo_stack_if #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             en;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             err_clr;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] top_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output en, push, pop, push_data, err_clr,
        input  pop_data, pop_valid, top_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  en, push, pop, push_data, err_clr,
        output pop_data, pop_valid, top_data, count, empty, full, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module   : lifo_stack
// Brief    : Parametrised LIFO return-address stack with replace, wrap and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int DEPTH    = 4,
    parameter int OVF_MODE = OVF_REJECT
) (
    input  wire logic    clk,
    input  wire logic    rst,
    lifo_stack_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] c_ptr_last  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_count_max = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [PW-1:0]    w_top_ptr;
    logic [PW-1:0]    w_inc_ptr;
    logic             w_empty;
    logic             w_full;
    stack_op_t        w_op;
    logic             w_mem_we;
    logic [PW-1:0]    w_mem_addr;
    logic [PW-1:0]    w_ptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_pop_fire;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_count_max);
    assign w_top_ptr = (r_wr_ptr == '0) ? c_ptr_last : r_wr_ptr - PW'(1);
    assign w_inc_ptr = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PW'(1);

    assign w_op      = decode_op(bus.en, bus.push, bus.pop, w_empty);
    assign w_unf_set = bus.en & bus.pop & w_empty;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_wr_ptr;
        w_ptr_nxt   = r_wr_ptr;
        w_count_nxt = r_count;
        w_pop_fire  = 1'b0;
        w_ovf_set   = 1'b0;
        case (w_op)
            OP_PUSH: begin
                if (!w_full) begin
                    w_mem_we    = 1'b1;
                    w_ptr_nxt   = w_inc_ptr;
                    w_count_nxt = r_count + CW'(1);
                end else begin
                    w_ovf_set = 1'b1;
                    // When full, wr_ptr already points at the oldest entry.
                    if (OVF_MODE == OVF_WRAP) begin
                        w_mem_we  = 1'b1;
                        w_ptr_nxt = w_inc_ptr;
                    end
                end
            end
            OP_POP: begin
                w_pop_fire  = 1'b1;
                w_ptr_nxt   = w_top_ptr;
                w_count_nxt = r_count - CW'(1);
            end
            OP_REPLACE: begin
                w_pop_fire = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = w_top_ptr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_ptr_nxt;
            r_count     <= w_count_nxt;
            r_pop_valid <= w_pop_fire;
            if (w_pop_fire) begin
                r_pop_data <= r_mem[w_top_ptr];
            end
            // A fresh error in the clearing cycle wins over err_clr.
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.err_clr);
            r_underflow <= w_unf_set | (r_underflow & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= bus.push_data;
        end
    end

    assign bus.pop_data  = r_pop_data;
    assign bus.pop_valid = r_pop_valid;
    assign bus.top_data  = w_empty ? '0 : r_mem[w_top_ptr];
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
`default_nettype wire
